// File: rtl/arch_map_table_v2_pkg.sv
// Shared types and default sizes for the architectural map table.
`default_nettype none

package arch_map_table_v2_pkg;

  localparam int RT_NUM         = 2;
  localparam int MT_ENTRY       = 32;
  localparam int TAG_IDX_WIDTH  = 6;
  localparam int ARCH_IDX_WIDTH = $clog2(MT_ENTRY);
  localparam int RESTORE_WIDTH  = 8;

  typedef struct packed {
    logic                      wr_en;
    logic [ARCH_IDX_WIDTH-1:0] arch_reg;
    logic [TAG_IDX_WIDTH-1:0]  tag;
  } RT_AMT;

  typedef struct packed {
    logic                     valid;
    logic [TAG_IDX_WIDTH-1:0] tag;
  } AMT_FL;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } AMT_STATE;

endpackage

`default_nettype wire

// File: rtl/arch_map_table_v2_retire_resolve.sv
// Combinational retire resolution: displaced tags and per-entry next values,
// ordered so that higher (younger) channels win same-register conflicts.
`default_nettype none

module amt_retire_resolve
  import arch_map_table_v2_pkg::*;
#(
  parameter int C_RT_NUM         = RT_NUM,
  parameter int C_MT_ENTRY       = MT_ENTRY,
  parameter int C_TAG_IDX_WIDTH  = TAG_IDX_WIDTH,
  parameter int C_ARCH_IDX_WIDTH = $clog2(C_MT_ENTRY)
) (
  input  RT_AMT [C_RT_NUM-1:0]                           rt_amt,
  input  logic  [C_MT_ENTRY-1:0][C_TAG_IDX_WIDTH-1:0]    amt,
  output AMT_FL [C_RT_NUM-1:0]                           fl,
  output logic  [C_MT_ENTRY-1:0][C_TAG_IDX_WIDTH-1:0]    amt_nxt,
  output logic  [C_MT_ENTRY-1:0]                         amt_we
);

  // A younger channel displaces whatever an older same-cycle channel wrote,
  // not the stale committed entry.
  always_comb begin
    for (int j = 0; j < C_RT_NUM; j++) begin
      fl[j].valid = rt_amt[j].wr_en;
      fl[j].tag   = amt[rt_amt[j].arch_reg];
      for (int i = 0; i < j; i++) begin
        if (rt_amt[i].wr_en && (rt_amt[i].arch_reg == rt_amt[j].arch_reg)) begin
          fl[j].tag = rt_amt[i].tag;
        end
      end
      if (!rt_amt[j].wr_en) begin
        fl[j].tag = '0;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < C_MT_ENTRY; e++) begin
      amt_we[e]  = 1'b0;
      amt_nxt[e] = amt[e];
      for (int j = 0; j < C_RT_NUM; j++) begin
        if (rt_amt[j].wr_en && (rt_amt[j].arch_reg == C_ARCH_IDX_WIDTH'(e))) begin
          amt_we[e]  = 1'b1;
          amt_nxt[e] = rt_amt[j].tag;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arch_map_table_v2.sv
// Architectural map table: committed arch->phys mapping with multi-retire
// update, free-list release and beat-wise restore to the speculative map.
`default_nettype none

module arch_map_table_v2
  import arch_map_table_v2_pkg::*;
#(
  parameter int C_RT_NUM         = RT_NUM,
  parameter int C_MT_ENTRY       = MT_ENTRY,
  parameter int C_TAG_IDX_WIDTH  = TAG_IDX_WIDTH,
  parameter int C_ARCH_IDX_WIDTH = $clog2(C_MT_ENTRY),
  parameter int C_RESTORE_WIDTH  = RESTORE_WIDTH
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  RT_AMT [C_RT_NUM-1:0]                            rt_amt_i,
  output AMT_FL [C_RT_NUM-1:0]                            amt_fl_o,
  input  logic                                            rollback_i,
  output logic                                            restore_valid_o,
  input  logic                                            restore_ready_i,
  output logic  [C_ARCH_IDX_WIDTH-1:0]                    restore_base_o,
  output logic  [C_RESTORE_WIDTH-1:0][C_TAG_IDX_WIDTH-1:0] restore_tag_o,
  output logic                                            busy_o,
  output logic  [C_MT_ENTRY-1:0][C_TAG_IDX_WIDTH-1:0]     amt_o
);

  localparam int NUM_BEATS = C_MT_ENTRY / C_RESTORE_WIDTH;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  AMT_STATE                                  state;
  AMT_STATE                                  state_next;
  logic [BEAT_W-1:0]                         beat;
  logic [C_MT_ENTRY-1:0][C_TAG_IDX_WIDTH-1:0] amt;
  logic [C_MT_ENTRY-1:0][C_TAG_IDX_WIDTH-1:0] amt_nxt;
  logic [C_MT_ENTRY-1:0]                     amt_we;
  AMT_FL [C_RT_NUM-1:0]                      fl_raw;
  logic                                      beat_fire;
  logic                                      last_beat;

  amt_retire_resolve #(
    .C_RT_NUM        (C_RT_NUM),
    .C_MT_ENTRY      (C_MT_ENTRY),
    .C_TAG_IDX_WIDTH (C_TAG_IDX_WIDTH),
    .C_ARCH_IDX_WIDTH(C_ARCH_IDX_WIDTH)
  ) u_resolve (
    .rt_amt (rt_amt_i),
    .amt    (amt),
    .fl     (fl_raw),
    .amt_nxt(amt_nxt),
    .amt_we (amt_we)
  );

  assign last_beat = (beat == BEAT_W'(NUM_BEATS - 1));
  assign beat_fire = (state == RESTORE) && restore_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rollback_i) state_next = RESTORE;
      RESTORE: if (beat_fire && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat <= '0;
    end else if (state == IDLE) begin
      beat <= '0;
    end else if (beat_fire) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  // Retires are only honoured in IDLE; a rollback cycle still commits them
  // so the restore stream carries the newest architectural state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < C_MT_ENTRY; e++) begin
        amt[e] <= C_TAG_IDX_WIDTH'(e);
      end
    end else if (state == IDLE) begin
      for (int e = 0; e < C_MT_ENTRY; e++) begin
        if (amt_we[e]) amt[e] <= amt_nxt[e];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < C_RT_NUM; j++) begin
      amt_fl_o[j] = fl_raw[j];
      if (state != IDLE) amt_fl_o[j].valid = 1'b0;
    end
  end

  always_comb begin
    restore_base_o = C_ARCH_IDX_WIDTH'(int'(beat) * C_RESTORE_WIDTH);
    for (int k = 0; k < C_RESTORE_WIDTH; k++) begin
      restore_tag_o[k] = amt[C_ARCH_IDX_WIDTH'(int'(restore_base_o) + k)];
    end
  end

  assign restore_valid_o = (state == RESTORE);
  assign busy_o          = (state == RESTORE);
  assign amt_o           = amt;

endmodule

`default_nettype wire

// File: tb/tb_arch_map_table_v2.sv
// Directed self-checking bench for arch_map_table_v2 (2 channels, 32 entries).
`default_nettype none

module tb_arch_map_table_v2;
  import arch_map_table_v2_pkg::*;

  logic                     clk;
  logic                     rst;
  RT_AMT [1:0]              rt;
  AMT_FL [1:0]              fl;
  logic                     rollback;
  logic                     rvalid;
  logic                     rready;
  logic [4:0]               rbase;
  logic [7:0][5:0]          rtag;
  logic                     busy;
  logic [31:0][5:0]         amt;

  int n_checks;
  int n_fail;

  arch_map_table_v2 #(
    .C_RT_NUM(2), .C_MT_ENTRY(32), .C_TAG_IDX_WIDTH(6), .C_RESTORE_WIDTH(8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rt_amt_i       (rt),
    .amt_fl_o       (fl),
    .rollback_i     (rollback),
    .restore_valid_o(rvalid),
    .restore_ready_i(rready),
    .restore_base_o (rbase),
    .restore_tag_o  (rtag),
    .busy_o         (busy),
    .amt_o          (amt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_rt(input int ch, input logic en, input int r, input int t);
    rt[ch].wr_en    = en;
    rt[ch].arch_reg = 5'(r);
    rt[ch].tag      = 6'(t);
  endtask

  task automatic check_beat(input int base, input string nm);
    check({nm, "_valid"}, 32'(rvalid), 1);
    check({nm, "_busy"}, 32'(busy), 1);
    check({nm, "_base"}, 32'(rbase), 32'(base));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rt       = '0;
    rollback = 1'b0;
    rready   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 32; i++) check($sformatf("rst_amt%0d", i), 32'(amt[i]), 32'(i));
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(rvalid), 0);
    check("rst_base", 32'(rbase), 0);
    check("rst_fl0_v", 32'(fl[0].valid), 0);
    check("rst_fl1_v", 32'(fl[1].valid), 0);

    // Independent retires
    set_rt(0, 1'b1, 3, 40);
    set_rt(1, 1'b1, 5, 41);
    #1;
    check("t2_fl0_v", 32'(fl[0].valid), 1);
    check("t2_fl0_t", 32'(fl[0].tag), 3);
    check("t2_fl1_v", 32'(fl[1].valid), 1);
    check("t2_fl1_t", 32'(fl[1].tag), 5);
    @(negedge clk);
    rt = '0;
    #1;
    check("t2_amt3", 32'(amt[3]), 40);
    check("t2_amt5", 32'(amt[5]), 41);
    check("t2_fl0_idle", 32'(fl[0].valid), 0);

    // Same arch reg on both channels
    set_rt(0, 1'b1, 7, 42);
    set_rt(1, 1'b1, 7, 43);
    #1;
    check("t3_fl0_t", 32'(fl[0].tag), 7);
    check("t3_fl1_v", 32'(fl[1].valid), 1);
    check("t3_fl1_t", 32'(fl[1].tag), 42);
    @(negedge clk);
    rt = '0;
    #1;
    check("t3_amt7", 32'(amt[7]), 43);

    // Rollback with a same-cycle retire, ready high
    @(negedge clk);
    rollback = 1'b1;
    set_rt(0, 1'b1, 3, 44);
    #1;
    check("t4_fl0_t", 32'(fl[0].tag), 40);
    check("t4_busy_pre", 32'(busy), 0);
    @(negedge clk);
    rollback = 1'b0;
    rt = '0;
    #1;
    check_beat(0, "t4_b0");
    check("t4_b0_k3", 32'(rtag[3]), 44);
    check("t4_b0_k5", 32'(rtag[5]), 41);
    check("t4_b0_k7", 32'(rtag[7]), 43);
    check("t4_b0_k0", 32'(rtag[0]), 0);
    @(negedge clk);
    check_beat(8, "t4_b1");
    check("t4_b1_k0", 32'(rtag[0]), 8);
    @(negedge clk);
    check_beat(16, "t4_b2");
    @(negedge clk);
    check_beat(24, "t4_b3");
    check("t4_b3_k7", 32'(rtag[7]), 31);
    @(negedge clk);
    check("t4_busy_end", 32'(busy), 0);
    check("t4_valid_end", 32'(rvalid), 0);
    check("t4_amt3", 32'(amt[3]), 44);

    // Rollback with ready stalled on beat 1, retires ignored during restore
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b1;
    #1;
    check_beat(0, "t5_b0");
    @(negedge clk);
    rollback = 1'b0;
    rready = 1'b0;
    set_rt(0, 1'b1, 9, 50);
    #1;
    check("t5_fl0_v", 32'(fl[0].valid), 0);
    for (int s = 0; s < 3; s++) begin
      check_beat(8, $sformatf("t5_stall%0d", s));
      check($sformatf("t5_stall%0d_k1", s), 32'(rtag[1]), 9);
      @(negedge clk);
    end
    check_beat(8, "t5_b1_go");
    rready = 1'b1;
    @(negedge clk);
    check_beat(16, "t5_b2");
    check("t5_amt9_mid", 32'(amt[9]), 9);
    @(negedge clk);
    check_beat(24, "t5_b3");
    rt = '0;
    @(negedge clk);
    check("t5_busy_end", 32'(busy), 0);
    check("t5_amt9", 32'(amt[9]), 9);

    // Reset during beat 2
    rollback = 1'b1;
    @(negedge clk);
    rollback = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_beat(16, "t6_b2");
    rst = 1'b1;
    #1;
    check("t6_valid", 32'(rvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_amt3", 32'(amt[3]), 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_amt7", 32'(amt[7]), 7);
    check("t6_amt5", 32'(amt[5]), 5);
    check("t6_base", 32'(rbase), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
